adder_digit_serial: RTL
=======================

# adder_digit_serial

Parametrised digit-serial adder/subtractor that computes a WIDTH-bit sum over WIDTH/DIGIT clock cycles.
- Each cycle, one DIGIT-bit ripple-carry slice processes one digit, least-significant first.
- A registered carry links consecutive digits.
- It is the sequential, width-generic successor to the team's fixed 4-bit combinational ripple adders.
- It sits between valid/ready producer and consumer stages wherever area matters more than throughput.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a+~b+1, i.e. a−b.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub, 1 = no borrow (a ≥ b unsigned).

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a into a register.
  - Latch b or ~b (per sub) into a register.
  - Carry register ← (sub ? 1 : cin); digit index ← 0; go to RUN.
- RUN, once per cycle:
  - Slice adds digit[idx] of the A and B registers plus the carry register.
  - The slice result is written to sum bits [idx*DIGIT +: DIGIT].
  - Carry register ← slice carry-out; idx increments.
  - When idx = N−1, the step completes and the FSM goes to DONE.
- DONE:
  - out_valid=1; sum and cout (= carry register) held stable.
  - On out_ready the FSM goes to IDLE. No new operand is accepted in the same cycle.
- in_valid/a/b/cin/sub are don't-care outside IDLE. Operands are captured only on the accept edge, so later input changes do not affect the result.
- The idx counter is $clog2(N) bits, minimum 1. It never exceeds N−1 and does not wrap in RUN.
- With N=1 the FSM spends exactly one cycle in RUN.

## Timing
- Reset (rst_n low, asynchronous):
  - State IDLE; in_ready=1; out_valid=0.
  - sum=0, cout=0, carry=0, idx=0.
  - Operand registers cleared.
- Reset asserted mid-RUN or in DONE discards the partial/held result immediately; no out_valid pulse follows.
- Latency:
  - Accept edge at cycle 0.
  - RUN occupies cycles 1..N.
  - out_valid rises after edge N, i.e. it is first high in cycle N+1.
- Throughput: at most one operation per N+2 cycles (IDLE accept, N RUN, ≥1 DONE).
- out_valid, once high, stays high with stable sum/cout until the cycle out_ready=1. It is low the cycle after.
- in_ready is low from the cycle after accept until the cycle after the DONE handshake.
- in_ready is a pure function of state (no combinational path from out_ready).

## Structure
- Shared package adder_pkg:
  - State enum (IDLE, RUN, DONE).
  - Localparam-computing function for N and the idx width.
  - Elaboration check that WIDTH % DIGIT == 0.
- One sub-module, adder_digit_slice:
  - Combinational, parameter DIGIT.
  - Ports a, b, cin → s, cout.
  - Per-bit generate/propagate ripple structure, same form as the existing fixed adders.
- Top holds the FSM, operand and sum registers, carry register and idx counter.

## Test plan
- WIDTH=8, DIGIT=4; a=0xFF, b=0x01, cin=0, sub=0 → out_valid first high 3 cycles after accept; sum=0x00, cout=1.
- WIDTH=8, DIGIT=4; a=0x05, b=0x07, sub=1, cin=1 (ignored) → sum=0xFE, cout=0. Repeat with a=0x07, b=0x05 → sum=0x02, cout=1.
- WIDTH=4, DIGIT=4 (N=1); a=0x9, b=0x8, cin=1 → sum=0x2, cout=1; out_valid first high 2 cycles after accept.
- Backpressure, WIDTH=32, DIGIT=4:
  - Stimulus: a=0x89ABCDEF, b=0x76543210, cin=1, then hold out_ready=0 for 5 cycles.
  - Required: sum=0x00000000, cout=1, stable throughout; in_ready=0 throughout.
  - Release: out_ready=1 → out_valid=0 next cycle; in_ready=1 the same cycle.
- Reset mid-op, WIDTH=32, DIGIT=4:
  - Stimulus: pull rst_n low during RUN idx=3.
  - Required: immediately sum=0, cout=0, out_valid=0, in_ready=1.
  - Next operation 1+2+0 → sum=3, cout=0.
- Randomised: 1000 operations, DIGIT ∈ {1,2,4,8}, WIDTH=32, random sub/cin and random in_valid/out_ready gaps. Required: each result matches a+b+cin or a−b with correct cout, every in_valid/in_ready handshake yields exactly one out_valid/out_ready handshake in order, and in_ready and out_valid are never high together.

Source files
------------

// File: rtl/adder_digit_serial_pkg.sv
// adder_pkg: shared state encoding and sizing helpers for the digit-serial adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int num_digits(int width, int digit);
    return width / digit;
  endfunction
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic bit width_ok(int width, int digit);
    return (digit >= 1) && (digit <= width) && (width % digit == 0);
  endfunction
endpackage

// File: rtl/adder_digit_slice.sv
// adder_digit_slice: combinational DIGIT-bit generate/propagate ripple-carry adder
module adder_digit_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);
  logic [DIGIT-1:0] g, p;
  logic c;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = p[i] ^ c;
      c = g[i] | (p[i] & c);
    end
    cout = c;
  end
endmodule

// File: rtl/adder_digit_serial.sv
// adder_digit_serial: WIDTH-bit add/subtract, one DIGIT-bit slice per cycle, valid/ready on both sides
module adder_digit_serial
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int IW = idx_width(N);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("adder_digit_serial: WIDTH must be a multiple of DIGIT");
  end

  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGIT-1:0] s_w;
  logic c_w, last;

  adder_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a(a_q[idx_q*DIGIT +: DIGIT]),
    .b(b_q[idx_q*DIGIT +: DIGIT]),
    .cin(carry_q),
    .s(s_w),
    .cout(c_w)
  );

  assign last = idx_q == IW'(N - 1);

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = sub ? ~b : b;
        carry_d = sub | cin;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*DIGIT +: DIGIT] = s_w;
        carry_d = c_w;
        idx_d = last ? idx_q : idx_q + 1'b1;
        state_d = last ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      idx_q <= idx_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign cout = carry_q;
endmodule
